mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data load/store.
// Latency: 3 cycles request-to-ready at zero-wait memory (grant, valid, ready pulse); one transaction in flight.
// Backpressure: requests are held until their ready pulse; MEM_ARBITER_STARVE_GUARD_EN bounds data-over-instr priority.
module mem_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_read_in,
    input  logic [ADDR_W-1:0]   instr_address_in,
    input  logic                instr_flush_in,
    output logic                instr_ready_out,
    output logic [DATA_W-1:0]   instr_read_value_out,
    input  logic                data_read_in,
    input  logic                data_write_in,
    input  logic [ADDR_W-1:0]   data_address_in,
    input  logic [DATA_W-1:0]   data_write_value_in,
    input  logic [DATA_W/8-1:0] data_write_mask_in,
    output logic                data_ready_out,
    output logic [DATA_W-1:0]   data_read_value_out,
    output logic                mem_valid_out,
    output logic                mem_write_out,
    output logic [ADDR_W-1:0]   mem_address_out,
    output logic [DATA_W-1:0]   mem_write_value_out,
    output logic [DATA_W/8-1:0] mem_write_mask_out,
    input  logic                mem_ready_in,
    input  logic [DATA_W-1:0]   mem_read_value_in,
    output logic                stall_out
);
    typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

    state_t state;
    logic   flushed;
    logic   data_req;
    logic   instr_req;
    logic   instr_first;
    logic   grant_data;
    logic   grant_instr;

    assign data_req    = data_read_in | data_write_in;
    assign instr_req   = instr_read_in & ~instr_flush_in;
    assign grant_data  = (state == IDLE) && data_req && !instr_first;
    assign grant_instr = (state == IDLE) && instr_req && !grant_data;
    assign stall_out   = instr_read_in & ~instr_ready_out;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign instr_first = instr_req && (starve_cnt >= CNT_W'(STARVE_LIMIT));

    // Counts data grants taken while a fetch was left waiting; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_instr) begin
            starve_cnt <= '0;
        end else if (grant_data && instr_read_in && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // STARVE_LIMIT is inert here: data always wins.
    assign instr_first = (STARVE_LIMIT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            flushed              <= 1'b0;
            mem_valid_out        <= 1'b0;
            mem_write_out        <= 1'b0;
            mem_address_out      <= '0;
            mem_write_value_out  <= '0;
            mem_write_mask_out   <= '0;
            instr_ready_out      <= 1'b0;
            data_ready_out       <= 1'b0;
            instr_read_value_out <= '0;
            data_read_value_out  <= '0;
        end else begin
            instr_ready_out <= 1'b0;
            data_ready_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state               <= DATA;
                        mem_valid_out       <= 1'b1;
                        mem_write_out       <= data_write_in;
                        mem_address_out     <= data_address_in;
                        mem_write_value_out <= data_write_value_in;
                        mem_write_mask_out  <= data_write_mask_in;
                    end else if (grant_instr) begin
                        state               <= INSTR;
                        flushed             <= 1'b0;
                        mem_valid_out       <= 1'b1;
                        mem_write_out       <= 1'b0;
                        mem_address_out     <= instr_address_in;
                        mem_write_value_out <= '0;
                        mem_write_mask_out  <= '0;
                    end
                end
                INSTR: begin
                    if (instr_flush_in) begin
                        flushed <= 1'b1;
                    end
                    // A flushed fetch still finishes on the bus but is never reported.
                    if (mem_ready_in) begin
                        state         <= IDLE;
                        mem_valid_out <= 1'b0;
                        if (!(flushed || instr_flush_in)) begin
                            instr_read_value_out <= mem_read_value_in;
                            instr_ready_out      <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (mem_ready_in) begin
                        state          <= IDLE;
                        mem_valid_out  <= 1'b0;
                        data_ready_out <= 1'b1;
                        if (!mem_write_out) begin
                            data_read_value_out <= mem_read_value_in;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(data_read_in && data_write_in));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small wait-state memory model; checks on the falling edge.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_read_in;
    logic [63:0] instr_address_in;
    logic        instr_flush_in;
    logic        instr_ready_out;
    logic [63:0] instr_read_value_out;
    logic        data_read_in;
    logic        data_write_in;
    logic [63:0] data_address_in;
    logic [63:0] data_write_value_in;
    logic [7:0]  data_write_mask_in;
    logic        data_ready_out;
    logic [63:0] data_read_value_out;
    logic        mem_valid_out;
    logic        mem_write_out;
    logic [63:0] mem_address_out;
    logic [63:0] mem_write_value_out;
    logic [7:0]  mem_write_mask_out;
    logic        mem_ready_in;
    logic [63:0] mem_read_value_in;
    logic        stall_out;

    int vectors = 0;
    int miscompares = 0;
    int mem_wait = 0;
    int wcnt = 0;

    always #5 clk = ~clk;

    // Memory answers after mem_wait stalled cycles of valid.
    assign mem_ready_in = mem_valid_out && (wcnt == mem_wait);
    always @(posedge clk or posedge rst) begin
        if (rst || !mem_valid_out || mem_ready_in) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    mem_arbiter dut (
        .clk                  (clk),
        .rst                  (rst),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_flush_in       (instr_flush_in),
        .instr_ready_out      (instr_ready_out),
        .instr_read_value_out (instr_read_value_out),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_address_in      (data_address_in),
        .data_write_value_in  (data_write_value_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_ready_out       (data_ready_out),
        .data_read_value_out  (data_read_value_out),
        .mem_valid_out        (mem_valid_out),
        .mem_write_out        (mem_write_out),
        .mem_address_out      (mem_address_out),
        .mem_write_value_out  (mem_write_value_out),
        .mem_write_mask_out   (mem_write_mask_out),
        .mem_ready_in         (mem_ready_in),
        .mem_read_value_in    (mem_read_value_in),
        .stall_out            (stall_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int  dcount;
    int  fetch_at;
    bit  fetch_seen;
    int  spurious;

    initial begin
        rst = 1'b1;
        instr_read_in = 0; instr_address_in = '0; instr_flush_in = 0;
        data_read_in = 0; data_write_in = 0; data_address_in = '0;
        data_write_value_in = '0; data_write_mask_in = '0;
        mem_read_value_in = '0;
        tick(); tick();
        chk("rst_valid", mem_valid_out, 0);
        chk("rst_iready", instr_ready_out, 0);
        chk("rst_dready", data_ready_out, 0);
        chk("rst_addr", mem_address_out, 0);
        chk("rst_stall", stall_out, 0);
        rst = 1'b0;
        tick();

        // Single zero-wait fetch.
        mem_wait = 0; mem_read_value_in = 64'hDEAD;
        instr_read_in = 1; instr_address_in = 64'h1000;
        #1;
        chk("f1_stall_c0", stall_out, 1);
        chk("f1_valid_c0", mem_valid_out, 0);
        tick();
        chk("f1_valid_c1", mem_valid_out, 1);
        chk("f1_addr_c1", mem_address_out, 64'h1000);
        chk("f1_write_c1", mem_write_out, 0);
        chk("f1_stall_c1", stall_out, 1);
        tick();
        chk("f1_ready_c2", instr_ready_out, 1);
        chk("f1_value_c2", instr_read_value_out, 64'hDEAD);
        chk("f1_stall_c2", stall_out, 0);
        chk("f1_valid_c2", mem_valid_out, 0);
        instr_read_in = 0;
        tick();
        chk("f1_ready_c3", instr_ready_out, 0);
        chk("f1_hold_c3", instr_read_value_out, 64'hDEAD);
        chk("f1_idle_c3", mem_valid_out, 0);

        // Load and fetch together: data first, fetch on the bus right after data_ready.
        mem_read_value_in = 64'h1234;
        data_read_in = 1; data_address_in = 64'h3000;
        instr_read_in = 1; instr_address_in = 64'h1100;
        tick();
        chk("ld_addr", mem_address_out, 64'h3000);
        chk("ld_write", mem_write_out, 0);
        tick();
        chk("ld_ready", data_ready_out, 1);
        chk("ld_value", data_read_value_out, 64'h1234);
        data_read_in = 0; mem_read_value_in = 64'h5678;
        tick();
        chk("ld_fetch_valid", mem_valid_out, 1);
        chk("ld_fetch_addr", mem_address_out, 64'h1100);
        tick();
        chk("ld_fetch_ready", instr_ready_out, 1);
        chk("ld_fetch_value", instr_read_value_out, 64'h5678);
        instr_read_in = 0;
        tick();

        // Fetch with 3 wait cycles.
        mem_wait = 3; mem_read_value_in = 64'hBEEF;
        instr_read_in = 1; instr_address_in = 64'h1200;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("ws_valid", mem_valid_out, 1);
            chk("ws_addr", mem_address_out, 64'h1200);
            chk("ws_noready", instr_ready_out, 0);
        end
        tick();
        chk("ws_ready", instr_ready_out, 1);
        chk("ws_value", instr_read_value_out, 64'hBEEF);
        instr_read_in = 0;
        tick();
        chk("ws_once", instr_ready_out, 0);

        // Flush during an outstanding fetch, then a fresh fetch.
        mem_wait = 2; mem_read_value_in = 64'hAAAA;
        instr_read_in = 1; instr_address_in = 64'h1300;
        tick();
        chk("fl_valid", mem_valid_out, 1);
        instr_read_in = 0; instr_flush_in = 1;
        tick();
        instr_flush_in = 0;
        tick();
        chk("fl_still_valid", mem_valid_out, 1);
        tick();
        chk("fl_no_ready", instr_ready_out, 0);
        chk("fl_done", mem_valid_out, 0);
        tick();
        chk("fl_no_ready2", instr_ready_out, 0);
        chk("fl_value_held", instr_read_value_out, 64'hBEEF);
        mem_wait = 0; mem_read_value_in = 64'h2222;
        instr_read_in = 1; instr_address_in = 64'h2000;
        tick();
        chk("fl_next_addr", mem_address_out, 64'h2000);
        tick();
        chk("fl_next_ready", instr_ready_out, 1);
        chk("fl_next_value", instr_read_value_out, 64'h2222);
        instr_read_in = 0;
        tick();

        // Flush in IDLE blocks the grant for that cycle only.
        instr_read_in = 1; instr_address_in = 64'h1400; instr_flush_in = 1;
        tick();
        chk("fi_blocked", mem_valid_out, 0);
        instr_flush_in = 0;
        tick();
        chk("fi_granted", mem_address_out, 64'h1400);
        chk("fi_valid", mem_valid_out, 1);
        tick();
        chk("fi_ready", instr_ready_out, 1);
        instr_read_in = 0;
        tick();

        // Store: fields on the bus, load result left untouched.
        data_write_in = 1; data_address_in = 64'h4000;
        data_write_value_in = 64'h77; data_write_mask_in = 8'h0F;
        tick();
        chk("st_write", mem_write_out, 1);
        chk("st_addr", mem_address_out, 64'h4000);
        chk("st_value", mem_write_value_out, 64'h77);
        chk("st_mask", mem_write_mask_out, 8'h0F);
        tick();
        chk("st_ready", data_ready_out, 1);
        chk("st_load_held", data_read_value_out, 64'h1234);
        data_write_in = 0;
        tick();

        // Continuous data traffic with a fetch waiting.
        dcount = 0; fetch_seen = 0; fetch_at = -1;
        mem_read_value_in = 64'h99;
        data_read_in = 1; data_address_in = 64'h5000;
        instr_read_in = 1; instr_address_in = 64'h1500;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (data_ready_out) dcount++;
            if (mem_valid_out && mem_address_out == 64'h1500 && !fetch_seen) begin
                fetch_seen = 1;
                fetch_at = dcount;
            end
        end
`ifdef MEM_ARBITER_STARVE_GUARD_EN
        chk("sv_fetch_seen", fetch_seen, 1);
        chk("sv_fetch_after", fetch_at, 4);
`else
        chk("sv_fetch_seen", fetch_seen, 0);
        chk("sv_data_done", dcount, 12);
`endif
        data_read_in = 0; instr_read_in = 0;
        for (int i = 0; i < 4; i++) tick();

        // Reset while a transaction is on the bus.
        mem_wait = 5;
        instr_read_in = 1; instr_address_in = 64'h1600;
        tick();
        chk("rm_valid", mem_valid_out, 1);
        tick();
        rst = 1; instr_read_in = 0;
        #1;
        chk("rm_valid0", mem_valid_out, 0);
        chk("rm_addr0", mem_address_out, 0);
        chk("rm_write0", mem_write_out, 0);
        chk("rm_iready0", instr_ready_out, 0);
        chk("rm_stall0", stall_out, 0);
        tick();
        rst = 0;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (instr_ready_out || data_ready_out || mem_valid_out) spurious++;
        end
        chk("rm_spurious", spurious, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
